// File: rtl/ahbl_apb_bridge_if.sv
// Bus bundle between the AHB-Lite splitter port, the AHB-to-APB bridge and its APB segment.
// The slave modport is the bridge's view; master is the view of everything around it.
interface ahbl_apb_bridge_if #(
  parameter int PADDR_W = 16
);
  logic               HSEL;
  logic [31:0]        HADDR;
  logic [1:0]         HTRANS;
  logic               HWRITE;
  logic               HREADY;
  logic [31:0]        HWDATA;
  logic               HREADYOUT;
  logic               HRESP;
  logic [31:0]        HRDATA;
  logic [PADDR_W-1:0] PADDR;
  logic               PSEL;
  logic               PENABLE;
  logic               PWRITE;
  logic [31:0]        PWDATA;
  logic [31:0]        PRDATA;
  logic               PREADY;
  logic               PSLVERR;

  modport slave (
    input  HSEL, HADDR, HTRANS, HWRITE, HREADY, HWDATA,
    output HREADYOUT, HRESP, HRDATA,
    output PADDR, PSEL, PENABLE, PWRITE, PWDATA,
    input  PRDATA, PREADY, PSLVERR
  );

  modport master (
    output HSEL, HADDR, HTRANS, HWRITE, HREADY, HWDATA,
    input  HREADYOUT, HRESP, HRDATA,
    input  PADDR, PSEL, PENABLE, PWRITE, PWDATA,
    output PRDATA, PREADY, PSLVERR
  );
endinterface

// File: rtl/ahbl_apb_bridge.sv
// AHB-Lite slave that turns one AHB transfer at a time into an APB access, holding the
// AHB data phase with wait states until the APB side completes; PSLVERR becomes a two-cycle ERROR.
module ahbl_apb_bridge #(
  parameter int PADDR_W = 16
) (
  input  logic              HCLK,
  input  logic              HRESETn,
  ahbl_apb_bridge_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LATCH,
    S_SETUP,
    S_ACCESS,
    S_DONE,
    S_ERR1,
    S_ERR2
  } state_t;

  state_t             state_q, state_d;
  logic [PADDR_W-1:0] paddr_q, paddr_d;
  logic               pwrite_q, pwrite_d;
  logic [31:0]        pwdata_q, pwdata_d;
  logic [31:0]        hrdata_q, hrdata_d;

  logic accept;
  logic hreadyout_c;
  logic hresp_c;
  logic psel_c;
  logic penable_c;

  // Address bits above the APB window and HTRANS[0] (SEQ vs NONSEQ) carry no meaning here.
  logic unused_bits;
  assign unused_bits = ^{bus.HADDR[31:PADDR_W], bus.HTRANS[0]};

  assign accept = bus.HSEL & bus.HTRANS[1] & bus.HREADY;

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      state_q  <= S_IDLE;
      paddr_q  <= '0;
      pwrite_q <= 1'b0;
      pwdata_q <= '0;
      hrdata_q <= '0;
    end else begin
      state_q  <= state_d;
      paddr_q  <= paddr_d;
      pwrite_q <= pwrite_d;
      pwdata_q <= pwdata_d;
      hrdata_q <= hrdata_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    paddr_d  = paddr_q;
    pwrite_d = pwrite_q;
    pwdata_d = pwdata_q;
    hrdata_d = hrdata_q;
    case (state_q)
      S_IDLE, S_DONE, S_ERR2: begin
        if (accept) begin
          state_d  = S_LATCH;
          paddr_d  = bus.HADDR[PADDR_W-1:0];
          pwrite_d = bus.HWRITE;
        end else begin
          state_d = S_IDLE;
        end
      end
      // HWDATA is only valid in the data phase, one cycle after the address was taken.
      S_LATCH: begin
        if (pwrite_q) pwdata_d = bus.HWDATA;
        state_d = S_SETUP;
      end
      S_SETUP: state_d = S_ACCESS;
      S_ACCESS: begin
        if (bus.PREADY) begin
          if (!pwrite_q) hrdata_d = bus.PRDATA;
          state_d = bus.PSLVERR ? S_ERR1 : S_DONE;
        end
      end
      S_ERR1:  state_d = S_ERR2;
      default: state_d = S_IDLE;
    endcase
  end

  // Bus strobes decode from the registered state only, so they cannot glitch on input changes.
  always_comb begin
    hreadyout_c = 1'b1;
    hresp_c     = 1'b0;
    psel_c      = 1'b0;
    penable_c   = 1'b0;
    case (state_q)
      S_LATCH:  hreadyout_c = 1'b0;
      S_SETUP: begin
        hreadyout_c = 1'b0;
        psel_c      = 1'b1;
      end
      S_ACCESS: begin
        hreadyout_c = 1'b0;
        psel_c      = 1'b1;
        penable_c   = 1'b1;
      end
      S_ERR1: begin
        hreadyout_c = 1'b0;
        hresp_c     = 1'b1;
      end
      S_ERR2:  hresp_c = 1'b1;
      default: ;
    endcase
  end

  assign bus.HREADYOUT = hreadyout_c;
  assign bus.HRESP     = hresp_c;
  assign bus.HRDATA    = hrdata_q;
  assign bus.PADDR     = paddr_q;
  assign bus.PSEL      = psel_c;
  assign bus.PENABLE   = penable_c;
  assign bus.PWRITE    = pwrite_q;
  assign bus.PWDATA    = pwdata_q;

endmodule

// File: tb/tb_ahbl_apb_bridge.sv
// Directed bench for ahbl_apb_bridge: a vector table of single transfers with hand-computed
// timing and data, plus hand-written sequences for reset, back-to-back and filtering.
module tb_ahbl_apb_bridge;

  logic HCLK = 1'b0;
  logic HRESETn = 1'b0;
  logic hready_block = 1'b0;
  int   n_pass = 0;
  int   n_total = 0;

  always #5 HCLK = ~HCLK;

  ahbl_apb_bridge_if #(.PADDR_W(16)) bus ();

  // The splitter returns this slave's own ready unless another port is stalling the bus.
  assign bus.HREADY = bus.HREADYOUT & ~hready_block;

  ahbl_apb_bridge #(.PADDR_W(16)) dut (
    .HCLK    (HCLK),
    .HRESETn (HRESETn),
    .bus     (bus)
  );

  typedef struct {
    logic [31:0] haddr;
    logic        hwrite;
    logic [31:0] hwdata;
    int          stall;
    logic [31:0] prdata;
    logic        err;
    logic [15:0] exp_paddr;
    int          exp_done;
    logic        exp_hresp;
    logic [31:0] exp_hrdata;
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic step();
    @(posedge HCLK);
    #1;
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int psel_c = 99;
    int pen_c = 99;
    int done_c = 99;
    int acc = 0;
    logic hresp_prev = 1'bx;
    logic hresp_done = 1'bx;
    logic [15:0] paddr_s = 'x;
    logic pwrite_s = 1'bx;
    logic [31:0] pwdata_s = 'x;
    logic [31:0] hrdata_s = 'x;
    bus.HSEL   = 1'b1;
    bus.HTRANS = 2'b10;
    bus.HADDR  = v.haddr;
    bus.HWRITE = v.hwrite;
    bus.PRDATA = v.prdata;
    bus.PREADY = 1'b1;
    bus.PSLVERR = 1'b1;
    for (int c = 1; c <= 20 && done_c == 99; c++) begin
      step();
      if (c == 1) begin
        bus.HSEL   = 1'b0;
        bus.HTRANS = 2'b00;
        bus.HADDR  = 32'h0;
        bus.HWDATA = v.hwdata;
      end
      if (bus.PSEL && psel_c == 99) psel_c = c;
      if (bus.PENABLE && pen_c == 99) pen_c = c;
      if (bus.PSEL && bus.PENABLE) begin
        paddr_s  = bus.PADDR;
        pwrite_s = bus.PWRITE;
        pwdata_s = bus.PWDATA;
        bus.PREADY  = (acc == v.stall);
        bus.PSLVERR = (acc == v.stall) ? v.err : 1'b1;
        acc++;
      end else begin
        // Outside ACCESS the bridge must ignore whatever the APB side shows.
        bus.PREADY  = 1'b1;
        bus.PSLVERR = 1'b1;
      end
      if (bus.HREADYOUT) begin
        done_c     = c;
        hresp_done = bus.HRESP;
        hrdata_s   = bus.HRDATA;
      end else begin
        hresp_prev = bus.HRESP;
      end
    end
    $display("xfer row%0d addr=%h write=%0b done_cyc=%0d hresp=%0b hrdata=%h",
             idx, v.haddr, v.hwrite, done_c, hresp_done, hrdata_s);
    chk($sformatf("row%0d paddr", idx), 32'(paddr_s), 32'(v.exp_paddr));
    chk($sformatf("row%0d pwrite", idx), 32'(pwrite_s), 32'(v.hwrite));
    if (v.hwrite) chk($sformatf("row%0d pwdata", idx), pwdata_s, v.hwdata);
    chk($sformatf("row%0d psel_cycle", idx), 32'(psel_c), 32'd2);
    chk($sformatf("row%0d penable_cycle", idx), 32'(pen_c), 32'd3);
    chk($sformatf("row%0d done_cycle", idx), 32'(done_c), 32'(v.exp_done));
    chk($sformatf("row%0d hresp_done", idx), 32'(hresp_done), 32'(v.exp_hresp));
    chk($sformatf("row%0d hresp_before_done", idx), 32'(hresp_prev), 32'(v.err));
    chk($sformatf("row%0d hrdata", idx), hrdata_s, v.exp_hrdata);
    bus.PREADY  = 1'b0;
    bus.PSLVERR = 1'b0;
    step();
    chk($sformatf("row%0d idle_hresp", idx), 32'(bus.HRESP), 32'd0);
    chk($sformatf("row%0d idle_hreadyout", idx), 32'(bus.HREADYOUT), 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0] = '{32'h4000_0010, 1'b1, 32'hCAFE_F00D, 0, 32'hBAD0_0000, 1'b0, 16'h0010, 4, 1'b0, 32'h0000_0000};
    vecs[1] = '{32'h4000_0020, 1'b0, 32'h0000_0000, 3, 32'h1234_5678, 1'b0, 16'h0020, 7, 1'b0, 32'h1234_5678};
    vecs[2] = '{32'h4001_ABCC, 1'b0, 32'h0000_0000, 0, 32'hDEAD_BEEF, 1'b1, 16'hABCC, 5, 1'b1, 32'hDEAD_BEEF};
    vecs[3] = '{32'h4000_FFFC, 1'b1, 32'h0000_0001, 1, 32'hBAD0_0001, 1'b1, 16'hFFFC, 6, 1'b1, 32'hDEAD_BEEF};
    vecs[4] = '{32'h5000_0004, 1'b1, 32'hA5A5_5A5A, 2, 32'hBAD0_0002, 1'b0, 16'h0004, 6, 1'b0, 32'hDEAD_BEEF};

    bus.HSEL = 1'b0; bus.HADDR = 32'h0; bus.HTRANS = 2'b00; bus.HWRITE = 1'b0;
    bus.HWDATA = 32'h0; bus.PRDATA = 32'h0; bus.PREADY = 1'b0; bus.PSLVERR = 1'b0;

    step();
    step();
    chk("reset hreadyout", 32'(bus.HREADYOUT), 32'd1);
    chk("reset hresp", 32'(bus.HRESP), 32'd0);
    chk("reset psel", 32'(bus.PSEL), 32'd0);
    chk("reset penable", 32'(bus.PENABLE), 32'd0);
    chk("reset hrdata", bus.HRDATA, 32'h0);
    chk("reset paddr", 32'(bus.PADDR), 32'h0);
    chk("reset pwdata", bus.PWDATA, 32'h0);
    HRESETn = 1'b1;
    step();

    for (int i = 0; i < 5; i++) run_vec(i, vecs[i]);

    // Reset asserted while the APB access is stalled in ACCESS.
    bus.HSEL = 1'b1; bus.HTRANS = 2'b10; bus.HADDR = 32'h4000_0044; bus.HWRITE = 1'b0;
    bus.PREADY = 1'b0; bus.PRDATA = 32'h5555_AAAA;
    step();
    bus.HSEL = 1'b0; bus.HTRANS = 2'b00;
    step();
    step();
    chk("rst_mid access_reached", 32'({bus.PSEL, bus.PENABLE}), 32'b11);
    HRESETn = 1'b0;
    step();
    $display("xfer reset_mid_access psel=%0b hreadyout=%0b hrdata=%h", bus.PSEL, bus.HREADYOUT, bus.HRDATA);
    chk("rst_mid psel", 32'(bus.PSEL), 32'd0);
    chk("rst_mid penable", 32'(bus.PENABLE), 32'd0);
    chk("rst_mid hreadyout", 32'(bus.HREADYOUT), 32'd1);
    chk("rst_mid hresp", 32'(bus.HRESP), 32'd0);
    chk("rst_mid hrdata", bus.HRDATA, 32'h0);
    chk("rst_mid paddr", 32'(bus.PADDR), 32'h0);
    chk("rst_mid pwdata", bus.PWDATA, 32'h0);
    step();
    HRESETn = 1'b1;
    bus.PREADY = 1'b1;
    step();
    chk("rst_mid after_release psel", 32'(bus.PSEL), 32'd0);
    chk("rst_mid after_release hreadyout", 32'(bus.HREADYOUT), 32'd1);

    // Back-to-back: second NONSEQ presented in the DONE cycle of the first.
    bus.PSLVERR = 1'b0; bus.PRDATA = 32'h7777_8888;
    bus.HSEL = 1'b1; bus.HTRANS = 2'b10; bus.HADDR = 32'h4000_0100; bus.HWRITE = 1'b1;
    step();
    bus.HSEL = 1'b0; bus.HTRANS = 2'b00; bus.HWDATA = 32'h1111_2222;
    step();
    step();
    step();
    chk("b2b first_done hreadyout", 32'(bus.HREADYOUT), 32'd1);
    chk("b2b first pwdata", bus.PWDATA, 32'h1111_2222);
    bus.HSEL = 1'b1; bus.HTRANS = 2'b10; bus.HADDR = 32'h4000_0200; bus.HWRITE = 1'b0;
    step();
    bus.HSEL = 1'b0; bus.HTRANS = 2'b00;
    chk("b2b latch psel", 32'(bus.PSEL), 32'd0);
    chk("b2b latch hreadyout", 32'(bus.HREADYOUT), 32'd0);
    step();
    chk("b2b setup psel", 32'(bus.PSEL), 32'd1);
    chk("b2b setup penable", 32'(bus.PENABLE), 32'd0);
    chk("b2b paddr", 32'(bus.PADDR), 32'h0200);
    chk("b2b pwrite", 32'(bus.PWRITE), 32'd0);
    step();
    step();
    $display("xfer back_to_back second hreadyout=%0b hrdata=%h", bus.HREADYOUT, bus.HRDATA);
    chk("b2b second_done hreadyout", 32'(bus.HREADYOUT), 32'd1);
    chk("b2b second hrdata", bus.HRDATA, 32'h7777_8888);
    step();

    // Filtering: IDLE/BUSY transfers and a NONSEQ while HREADY is low start nothing.
    bus.HSEL = 1'b1; bus.HADDR = 32'h4000_0300; bus.HWRITE = 1'b1;
    for (int k = 0; k < 6; k++) begin
      bus.HTRANS = (k < 3) ? 2'b00 : (k < 5) ? 2'b01 : 2'b10;
      hready_block = (k == 5);
      step();
      if (k == 5) begin
        hready_block = 1'b0;
        bus.HSEL = 1'b0;
        bus.HTRANS = 2'b00;
      end
      chk($sformatf("filter%0d psel", k), 32'(bus.PSEL), 32'd0);
      chk($sformatf("filter%0d hreadyout", k), 32'(bus.HREADYOUT), 32'd1);
    end
    step();
    chk("filter end psel", 32'(bus.PSEL), 32'd0);
    $display("xfer filtering psel=%0b hreadyout=%0b", bus.PSEL, bus.HREADYOUT);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
